// File: rtl/screen_scanner_if.sv
// RAM read port and pixel stream bundle between screen_scanner (master) and its
// memory/back end (slave).
interface screen_scanner_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_sof,
    output pix_eol
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_sof,
    input  pix_eol
  );
endinterface

// File: rtl/screen_scanner.sv
// Streams the screen RAM in raster order as a valid/ready pixel stream.
// Define SCREEN_SCANNER_CONTINUOUS_EN to scan frames back to back until reset.
//
// state  | meaning
// IDLE   | waiting for enable, buffers empty, no reads issued
// RUN    | fetching words and streaming pixels of the current frame
module screen_scanner #(
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256,
  parameter int ADDR_W        = 13
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  screen_scanner_if.master bus,
  output logic             frame_done_o,
  output logic             busy_o
);

`ifdef SCREEN_SCANNER_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  localparam int TOTAL_WORDS = WORDS_PER_ROW * ROWS;
  localparam int ROW_PIX     = WORDS_PER_ROW * 16;
  localparam int TOTAL_PIX   = TOTAL_WORDS * 16;
  localparam int PIX_W       = $clog2(TOTAL_PIX);
  localparam int COL_W       = $clog2(ROW_PIX);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(TOTAL_WORDS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(TOTAL_PIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(ROW_PIX - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rvalid_q;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              fetch_end_q, fetch_end_d;

  logic [15:0]       sh_q, sh_d;
  logic [4:0]        sh_cnt_q, sh_cnt_d;
  logic [15:0]       pf_q, pf_d;
  logic              pf_full_q, pf_full_d;

  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              frame_done_q;

  logic              pix_valid;
  logic              accept;
  logic              last_accept;
  logic              start;
  logic              shift_take;
  logic              issue;
  logic [ADDR_W-1:0] fetch_addr;

  assign pix_valid   = (sh_cnt_q != 5'd0);
  assign accept      = pix_valid & bus.pix_ready;
  assign last_accept = accept & (pix_cnt_q == LAST_PIX);
  assign start       = (state_q == S_IDLE) & enable_i;
  // The shift register can take a new word when empty or emptying this cycle.
  assign shift_take  = (sh_cnt_q == 5'd0) | (accept & (sh_cnt_q == 5'd1));
  assign fetch_addr  = start ? '0 : wcnt_q;
  assign issue       = start |
                       ((state_q == S_RUN) & ~pf_full_q & ~mem_rd_q & ~rvalid_q & ~fetch_end_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_RUN;
      S_RUN:  if (last_accept && !CONTINUOUS) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    if (state_q == S_RUN) busy_o = 1'b1;
  end

  always_comb begin
    mem_rd_d    = issue;
    mem_addr_d  = issue ? fetch_addr : mem_addr_q;
    wcnt_d      = wcnt_q;
    fetch_end_d = fetch_end_q;
    if (start) fetch_end_d = 1'b0;
    if (issue) begin
      wcnt_d = (fetch_addr == LAST_WORD) ? '0 : fetch_addr + 1'b1;
      if (fetch_addr == LAST_WORD && !CONTINUOUS) fetch_end_d = 1'b1;
    end
  end

  // Returned data never overtakes the prefetch word, so pixel order is preserved.
  always_comb begin
    sh_d      = sh_q;
    sh_cnt_d  = sh_cnt_q;
    pf_d      = pf_q;
    pf_full_d = pf_full_q;
    if (shift_take) begin
      if (pf_full_q) begin
        sh_d      = pf_q;
        sh_cnt_d  = 5'd16;
        pf_full_d = rvalid_q;
        if (rvalid_q) pf_d = bus.mem_data;
      end else if (rvalid_q) begin
        sh_d     = bus.mem_data;
        sh_cnt_d = 5'd16;
      end else begin
        sh_d     = '0;
        sh_cnt_d = 5'd0;
      end
    end else begin
      if (accept) begin
        sh_d     = {1'b0, sh_q[15:1]};
        sh_cnt_d = sh_cnt_q - 5'd1;
      end
      if (rvalid_q) begin
        pf_d      = bus.mem_data;
        pf_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    col_d     = col_q;
    if (accept) begin
      pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
      col_d     = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      wcnt_q       <= '0;
      fetch_end_q  <= 1'b0;
      sh_q         <= '0;
      sh_cnt_q     <= 5'd0;
      pf_q         <= '0;
      pf_full_q    <= 1'b0;
      pix_cnt_q    <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      rvalid_q     <= mem_rd_q;
      wcnt_q       <= wcnt_d;
      fetch_end_q  <= fetch_end_d;
      sh_q         <= sh_d;
      sh_cnt_q     <= sh_cnt_d;
      pf_q         <= pf_d;
      pf_full_q    <= pf_full_d;
      pix_cnt_q    <= pix_cnt_d;
      col_q        <= col_d;
      frame_done_q <= last_accept;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = sh_q[0];
  assign bus.pix_sof   = pix_valid & (pix_cnt_q == '0);
  assign bus.pix_eol   = pix_valid & (col_q == LAST_COL);
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_screen_scanner.sv
// Directed/randomized bench for screen_scanner on a reduced 4x8-word screen.
module tb_screen_scanner;
  localparam int WPR     = 4;
  localparam int ROWS    = 8;
  localparam int AW      = 5;
  localparam int TW      = WPR * ROWS;
  localparam int ROW_PIX = WPR * 16;
  localparam int TP      = TW * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_done;
  logic busy;
  logic [15:0] mem [TW];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  screen_scanner_if #(.ADDR_W(AW)) bus_if ();

  screen_scanner #(.WORDS_PER_ROW(WPR), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .bus          (bus_if.master),
    .frame_done_o (frame_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM: data valid the cycle after the strobe
  always @(posedge clk) if (bus_if.mem_rd) bus_if.mem_data <= mem[bus_if.mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pix(input int p);
    logic [15:0] w;
    w = mem[p / 16];
    return w[p % 16];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_mem_rd", bus_if.mem_rd, 0);
    check("rst_mem_addr", bus_if.mem_addr, 0);
    check("rst_pix_valid", bus_if.pix_valid, 0);
    check("rst_pix_flags", {bus_if.pix_data, bus_if.pix_sof, bus_if.pix_eol}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < TW; i++) mem[i] = 16'($urandom);
  endtask

  task automatic run_frame(input int pct, input int stop_at, input bit en_noise);
    int idx, n, first, acc_cyc, reads, gaps, quiet;
    bit done, stalled, prev_rd;
    logic [2:0] held;
    logic [AW:0] exp_addr;
    idx = 0; n = 0; first = -1; acc_cyc = -10; reads = 0; gaps = 0;
    done = 0; stalled = 0; prev_rd = 0; exp_addr = '0; held = '0;
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    check("start_mem_rd", bus_if.mem_rd, 1);
    check("start_mem_addr", bus_if.mem_addr, 0);
    check("start_busy", busy, 1);
    while (!done && n < 40 * TP) begin
      if (bus_if.mem_rd) begin
        check("rd_addr", bus_if.mem_addr, exp_addr);
        check("rd_back_to_back", prev_rd, 0);
        exp_addr++;
        reads++;
      end
      prev_rd = bus_if.mem_rd;
      if (bus_if.pix_valid && first < 0) first = n;
      if (first >= 0 && idx < TP && !bus_if.pix_valid) gaps++;
      if (stalled)
        check("stall_hold", {bus_if.pix_valid, bus_if.pix_data, bus_if.pix_sof, bus_if.pix_eol},
              {1'b1, held});
      if (frame_done) begin
        check("done_timing", n, acc_cyc + 1);
        check("done_count", idx, TP);
        check("done_busy", busy, 0);
        done = 1;
      end
      bus_if.pix_ready = ($urandom_range(99) < pct);
      stalled = bus_if.pix_valid && !bus_if.pix_ready;
      held = {bus_if.pix_data, bus_if.pix_sof, bus_if.pix_eol};
      if (bus_if.pix_valid && bus_if.pix_ready) begin
        check("pix_data", bus_if.pix_data, exp_pix(idx));
        check("pix_sof", bus_if.pix_sof, idx == 0);
        check("pix_eol", bus_if.pix_eol, (idx % ROW_PIX) == ROW_PIX - 1);
        idx++;
        acc_cyc = n;
        if (idx == stop_at) return;
      end
      if (en_noise) enable = (idx < TP) ? ($urandom_range(1) == 1) : 1'b0;
      if (!done) begin
        cyc();
        n++;
      end
    end
    enable = 1'b0;
    check("frame_finished", done, 1);
    check("first_latency", first, 2);
    check("frame_reads", reads, TW);
    if (pct == 100) check("no_bubbles", gaps, 0);
    if (done) begin
      cyc();
      check("done_single_pulse", frame_done, 0);
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
        quiet += int'(bus_if.mem_rd) + int'(bus_if.pix_valid) + int'(busy);
        cyc();
      end
      check("idle_after_frame", quiet, 0);
    end
  endtask

  initial begin
    bus_if.pix_ready = 1'b0;
    #12;
    reset_checks();
    #8;
    rst_n = 1'b1;

    // single black pixel at the top-left corner, consumer always ready
    for (int i = 0; i < TW; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    run_frame(100, TP + 1, 1'b0);

    // random image, 50% back-pressure, enable toggling during the frame
    fill_random();
    run_frame(50, TP + 1, 1'b1);

    // only the bottom-right pixel of the last word is black in that word
    fill_random();
    mem[TW - 1] = 16'h8000;
    run_frame(70, TP + 1, 1'b0);

    // reset mid-frame, then a clean restart from address 0
    fill_random();
    run_frame(60, 100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    #2;
    rst_n = 1'b1;
    bus_if.pix_ready = 1'b0;
    fill_random();
    run_frame(100, TP + 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/screen_scanner.md
# screen_scanner

Read-side companion to the Hack screen memory: walks the 8K x 16 screen RAM and streams its 131072 pixels in raster order over a valid/ready pixel interface toward a display/serializer back end. It owns the RAM read port (address plus read strobe; data returns one cycle later) and double-buffers words so a consumer holding ready high gets one pixel per clock after the initial fetch.

## Interface
- WORDS_PER_ROW, 32: words per scan line (512 px / 16).
- ROWS, 256: scan lines per frame.
- ADDR_W, 13: RAM address width; must satisfy 2^ADDR_W >= WORDS_PER_ROW*ROWS.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- mem_addr  out  ADDR_W  RAM read address (registered).
- mem_rd  out  1  read strobe (registered); one word per high cycle.
- mem_data  in  16  read data; valid in the cycle after mem_rd was high.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel when valid&ready.
- pix_data  out  1  pixel value, 1 = black.
- pix_sof  out  1  high with pixel 0 of a frame.
- pix_eol  out  1  high with last pixel (column 511) of every line.
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted.
- busy  out  1  high from frame start until frame_done.

## Operation
- Reset: all outputs 0, FSM IDLE, buffers empty, word counter 0.
- States: IDLE -> RUN on enable=1; RUN -> IDLE when last pixel accepted (continuous mode: see Configuration).
- Pixel (r,c) = bit c%16 of word r*WORDS_PER_ROW + c/16; bit 0 emitted first (leftmost).
- Buffers: shift register (16 bits + 5-bit remaining count) and one prefetch register with full flag.
- Fetch rule: issue mem_rd when prefetch empty, no read outstanding, words remain in frame. Returned data loads the shift register if it is empty or draining its last pixel that cycle, else the prefetch register; never dropped.
- Shift advances only on valid&ready; pix_data/pix_sof/pix_eol held stable while valid&~ready.
- Word counter wraps to 0 after WORDS_PER_ROW*ROWS-1; mem_addr never exceeds 8191.
- enable ignored in RUN; deasserting mid-frame does not abort.
- Reset mid-frame: immediate abort, outstanding read discarded, next frame restarts at address 0.

## Timing
- Cycle N: IDLE, enable=1. N+1: mem_rd=1, mem_addr=0, busy=1. N+2: mem_data valid, captured at end of cycle. N+3: pix_valid=1, pix_sof=1.
- Latency enable-to-first-pixel: 3 cycles.
- Sustained throughput with pix_ready=1: one pixel per cycle, no bubbles after first pixel.
- frame_done: high the cycle after acceptance of pixel 131071; busy falls same cycle.
- Next frame (non-continuous): enable sampled in IDLE the cycle frame_done is high at earliest.

## Configuration
- SCREEN_SCANNER_CONTINUOUS_EN defined: after the final word fetch, counter wraps and fetching continues into next frame; state stays RUN; pix_sof on pixel 0 of each frame with zero bubble at the boundary if ready held; frame_done pulses every frame; busy stays high; stops only on reset.
- Not defined: single frame per start; returns to IDLE after frame_done; enable must be sampled again.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously, mem_rd=0, mem_addr=0.
- RAM word0=0x0001 else 0, ready=1, enable one cycle -> pix_valid at N+3 with pix_data=1, pix_sof=1; pixels 1-511 =0; pix_eol on pixel 511 only; 131072 pixels contiguous.
- Random image, pix_ready random 50% -> output stream bit-exact vs model; outputs stable during every stall; never two reads outstanding.
- Word 8191=0x8000 -> pixel 131071 =1 with pix_eol=1; frame_done one pulse next cycle; busy=0; no mem_rd after address 8191 (non-continuous).
- Pulse rst_n low at pixel 1000 then enable -> restart at address 0, first pixel matches word 0 bit 0 with pix_sof=1.
- With SCREEN_SCANNER_CONTINUOUS_EN, ready=1 -> frames back to back, pix_sof on pixels 0 and 131072, no idle cycle between, frame_done each frame, mem_addr wraps 8191->0.
